mbl_msg_rd_arb: RTL and testbench
=================================

Name: mbl_msg_rd_arb

Overview:
Multi-channel message read engine, generalising the single-channel msg_busy/mem_rd_req/mem_rd_gnt child to NUM_CH request channels. Each channel queues read requests in a private FIFO. A round-robin arbiter serialises the queued requests onto one shared memory read port, and read data returns to the originating channel over a per-channel valid/ready response. It sits between the message-bus request agents and the memory read port.

Parameters:
NUM_CH, 4, number of request channels (≥2).
ADDR_W, 16, memory read address width.
DATA_W, 32, memory read data width.
DEPTH, 4, per-channel request FIFO depth (power of 2, ≥2).

Ports:
clk  in  1  clock; all logic rising-edge.
reset_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_CH  per-channel request valid.
req_ready  out  NUM_CH  per-channel FIFO not full.
req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
resp_valid  out  NUM_CH  one-hot response valid.
resp_ready  in  NUM_CH  per-channel response ready.
resp_data  out  DATA_W  response data, shared by all channels.
mem_rd_req  out  1  memory read request.
mem_rd_addr  out  ADDR_W  memory read address.
mem_rd_gnt  in  1  memory grant.
mem_rd_valid  in  1  memory read data valid.
mem_rd_data  in  DATA_W  memory read data.
msg_busy  out  NUM_CH  channel FIFO non-empty or channel in service.
err_unexp_valid  out  1  sticky flag: mem_rd_valid seen outside WAIT.

Behaviour:
- Reset (async assert, sync-free release): all outputs 0. FIFOs empty. Arbiter pointer = 0. FSM = IDLE. req_ready = all-ones from the first cycle after release.
- Request push: a channel pushes when req_valid[i] && req_ready[i] at the clock edge. req_ready[i] = !full[i], registered-count based. A push while full cannot occur.
- FSM states:
  - IDLE: if any FIFO is non-empty, select the first non-empty channel at or after the pointer (wrapping NUM_CH-1→0). Latch its channel index and head address, then go to REQ. Pointer = selected+1 mod NUM_CH.
  - REQ: mem_rd_req=1 and mem_rd_addr=latched address, both held stable until mem_rd_gnt is sampled high. On that edge: pop the selected FIFO and go to WAIT.
  - WAIT: mem_rd_req=0. On mem_rd_valid, register mem_rd_data into resp_data and go to RESP.
  - RESP: resp_valid[sel]=1 and resp_data held until resp_ready[sel] is sampled high. On that edge go to IDLE.
- Exactly one read is outstanding at a time. Minimum latency: push at edge E0 → mem_rd_req high after E1. Best case, one transaction per 4 cycles.
- Simultaneous push and pop on the same FIFO: count unchanged, ordering preserved.
- Per-channel order is FIFO. Across channels, order is round-robin among non-empty channels at each IDLE decision.
- msg_busy[i] = FIFO i non-empty OR (FSM≠IDLE AND sel==i).
- mem_rd_valid in IDLE, REQ or RESP: data is ignored and err_unexp_valid is set. The flag clears only on reset.
- mem_rd_gnt outside REQ: ignored.
- Reset mid-transaction: state and FIFOs are discarded. A late mem_rd_valid after release sets err_unexp_valid.
- No combinational path from any input to req_ready, resp_valid or mem_rd_req.

Decomposition:
- Package mbl_msg_pkg:
  - state enum rd_state_t {IDLE, REQ, WAIT, RESP}.
  - ch_idx width localparam function ($clog2(NUM_CH)).
- Sub-module mbl_msg_fifo: parametrised by width and depth, with push/pop/full/empty/count. Instantiated NUM_CH times via generate.
- Top level contains the arbiter and FSM.

Test Plan:
- Single request: ch2 pushes addr 0x1234; gnt in the same cycle as req; mem_rd_valid 2 cycles later with 0xDEADBEEF. → mem_rd_req rises exactly 1 cycle after push. resp_valid=4'b0100 with resp_data 0xDEADBEEF. msg_busy[2] falls after the resp handshake.
- Fairness: all 4 channels hold 2 requests each, gnt tied high, immediate valid/ready. → service order ch0,1,2,3,0,1,2,3.
- Back-pressure: ch1 pushes 4 requests while mem_rd_gnt=0. → req_ready[1]=0 after the 4th push. A 5th push is held. req_ready[1] returns the cycle after gnt pops one entry.
- Response stall: resp_ready=0 for 10 cycles in RESP. → resp_valid and resp_data are stable. mem_rd_req stays 0 and no new grant is taken until the handshake.
- Error: pulse mem_rd_valid in IDLE. → err_unexp_valid=1 and no resp_valid. The flag stays set until reset_n is asserted.
- Mid-operation reset: assert reset_n=0 during WAIT. → all outputs 0 asynchronously. After release, FIFOs are empty and req_ready is all-ones.

Source files
------------

// File: rtl/mbl_msg_pkg.sv
// Shared types and helpers for the multi-channel message read engine.
package mbl_msg_pkg;

  // Read engine FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } rd_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mbl_msg_fifo.sv
// Small synchronous FIFO holding one channel's pending read addresses.
module mbl_msg_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking; pointers wrap naturally as Depth is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mbl_msg_rd_arb.sv
// Multi-channel message read engine: per-channel request FIFOs, round-robin
// arbitration onto one memory read port, one read outstanding at a time.
module mbl_msg_rd_arb
  import mbl_msg_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  output logic [NUM_CH-1:0]        resp_valid,
  input  logic [NUM_CH-1:0]        resp_ready,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     mem_rd_req,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic                     mem_rd_gnt,
  input  logic                     mem_rd_valid,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic [NUM_CH-1:0]        msg_busy,
  output logic                     err_unexp_valid
);

  localparam int unsigned ChW = ch_idx_w(NUM_CH);

  rd_state_t         state_q, state_d;
  logic [ChW-1:0]    sel_q, sel_d;
  logic [ChW-1:0]    ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rdy_en_q;
  logic              err_q;

  logic [NUM_CH-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] head_addr  [NUM_CH];
  logic [$clog2(DEPTH):0] fifo_count [NUM_CH];
  logic              unused_count;

  logic              pick_found;
  logic [ChW-1:0]    pick_idx;

  // req_ready is held low in reset and depends only on registered state.
  assign req_ready = {NUM_CH{rdy_en_q}} & ~fifo_full;
  assign fifo_push = req_valid & req_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fifo
    mbl_msg_fifo #(
      .Width (ADDR_W),
      .Depth (DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (fifo_push[i]),
      .wdata_i (req_addr[i*ADDR_W +: ADDR_W]),
      .pop_i   (fifo_pop[i]),
      .rdata_o (head_addr[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i]),
      .count_o (fifo_count[i])
    );
  end

  // Occupancy counts are exposed by the FIFO but only full/empty are needed here.
  always_comb begin
    unused_count = 1'b0;
    for (int i = 0; i < NUM_CH; i++) unused_count = unused_count ^ (^fifo_count[i]);
  end

  // Pop the selected channel on the edge its grant is accepted.
  always_comb begin
    fifo_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((state_q == REQ) && mem_rd_gnt && (sel_q == ChW'(i))) fifo_pop[i] = 1'b1;
    end
  end

  // Round-robin pick: first non-empty channel at or after the pointer.
  always_comb begin
    int unsigned idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!pick_found && !fifo_empty[idx]) begin
        pick_found = 1'b1;
        pick_idx   = ChW'(idx);
      end
    end
  end

  // Next-state logic for the read FSM and its latched transaction fields.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          addr_d  = head_addr[pick_idx];
          ptr_d   = (pick_idx == ChW'(NUM_CH - 1)) ? '0 : pick_idx + ChW'(1);
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_rd_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rd_valid) begin
          data_d  = mem_rd_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready[sel_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and transaction registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Sticky flag for read data arriving when no read is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (mem_rd_valid && (state_q != WAIT)) begin
      err_q <= 1'b1;
    end
  end

  // Registered-state-only outputs.
  always_comb begin
    resp_valid = '0;
    msg_busy   = ~fifo_empty;
    if (state_q == RESP) resp_valid[sel_q] = 1'b1;
    if (state_q != IDLE) msg_busy[sel_q] = 1'b1;
  end

  assign mem_rd_req      = (state_q == REQ);
  assign mem_rd_addr     = addr_q;
  assign resp_data       = data_q;
  assign err_unexp_valid = err_q;

endmodule

// File: tb/tb_mbl_msg_rd_arb.sv
// Directed self-checking bench for mbl_msg_rd_arb.
module tb_mbl_msg_rd_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_addr;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [31:0] resp_data;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [3:0]  msg_busy;
  logic        err_unexp_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mbl_msg_rd_arb #(
    .NUM_CH (4),
    .ADDR_W (16),
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_data       (resp_data),
    .mem_rd_req      (mem_rd_req),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_gnt      (mem_rd_gnt),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .msg_busy        (msg_busy),
    .err_unexp_valid (err_unexp_valid)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push(input int ch, input logic [15:0] addr);
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_addr[ch*16 +: 16] = addr;
    tick();
    req_valid = '0;
  endtask

  // Serve one read end to end, expecting it to belong to channel ch.
  task automatic do_txn(input int ch, input logic [15:0] addr, input logic [31:0] data);
    logic [3:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    for (int t = 0; t < 16 && mem_rd_req !== 1'b1; t++) tick();
    check("txn_req", mem_rd_req, 1);
    check("txn_addr", mem_rd_addr, addr);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    check("txn_req_drop", mem_rd_req, 0);
    mem_rd_valid = 1'b1;
    mem_rd_data = data;
    tick();
    mem_rd_valid = 1'b0;
    check("txn_resp_valid", resp_valid, oh);
    check("txn_resp_data", resp_data, data);
    resp_ready = oh;
    tick();
    resp_ready = '0;
    check("txn_resp_done", resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_addr = '0;
    mem_rd_data = '0;
    reset_n = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_rd_req", mem_rd_req, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_busy", msg_busy, 0);
    check("rst_err", err_unexp_valid, 0);
    reset_n = 1'b1;
    tick();
    check("rel_req_ready", req_ready, 4'hF);

    // Single request on ch2 with grant already high.
    mem_rd_gnt = 1'b1;
    push(2, 16'h1234);
    check("single_no_req_yet", mem_rd_req, 0);
    check("single_busy", msg_busy, 4'b0100);
    tick();
    check("single_req_rise", mem_rd_req, 1);
    check("single_addr", mem_rd_addr, 16'h1234);
    tick();
    mem_rd_gnt = 1'b0;
    check("single_req_fall", mem_rd_req, 0);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hDEADBEEF;
    tick();
    mem_rd_valid = 1'b0;
    check("single_resp_valid", resp_valid, 4'b0100);
    check("single_resp_data", resp_data, 32'hDEADBEEF);
    check("single_busy_resp", msg_busy, 4'b0100);
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    check("single_resp_done", resp_valid, 0);
    check("single_busy_done", msg_busy, 0);
    check("single_no_err", err_unexp_valid, 0);

    // Fairness: two requests in every channel, served round-robin from ch0.
    apply_reset();
    for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = 16'(16'h1000 * (i + 1));
    req_valid = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = 16'(16'h1000 * (i + 1) + 1);
    tick();
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      do_txn(k % 4, 16'(16'h1000 * ((k % 4) + 1) + (k / 4)), 32'hF0000000 | 32'(k));
    end

    // Back-pressure on ch1 with the grant withheld.
    apply_reset();
    for (int n = 0; n < 4; n++) begin
      req_valid = 4'b0010;
      req_addr[16 +: 16] = 16'(16'h2000 + n);
      tick();
    end
    check("bp_full", req_ready, 4'b1101);
    req_addr[16 +: 16] = 16'h2004;
    tick();
    check("bp_held", req_ready, 4'b1101);
    check("bp_addr", mem_rd_addr, 16'h2000);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    req_valid = '0;
    check("bp_ready_back", req_ready, 4'hF);
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h00002000;
    tick();
    mem_rd_valid = 1'b0;
    check("bp_resp0", resp_valid, 4'b0010);
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
    for (int n = 1; n < 4; n++) do_txn(1, 16'(16'h2000 + n), 32'(n));
    tick();
    tick();
    check("bp_no_fifth", mem_rd_req, 0);
    check("bp_idle_busy", msg_busy, 0);

    // Response stall: hold resp_ready low while another channel waits.
    apply_reset();
    push(3, 16'h3333);
    tick();
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hCAFEF00D;
    tick();
    mem_rd_valid = 1'b0;
    push(0, 16'h0A0A);
    mem_rd_gnt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("stall_valid", resp_valid, 4'b1000);
      check("stall_data", resp_data, 32'hCAFEF00D);
      check("stall_no_req", mem_rd_req, 0);
      tick();
    end
    resp_ready = 4'b1000;
    tick();
    resp_ready = '0;
    mem_rd_gnt = 1'b0;
    check("stall_done", resp_valid, 0);
    do_txn(0, 16'h0A0A, 32'h12345678);

    // Unexpected read data while idle.
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hBAD0BAD0;
    tick();
    mem_rd_valid = 1'b0;
    check("err_set", err_unexp_valid, 1);
    check("err_no_resp", resp_valid, 0);
    for (int c = 0; c < 3; c++) tick();
    check("err_sticky", err_unexp_valid, 1);
    check("err_no_req", mem_rd_req, 0);

    // Reset during WAIT with queued work behind it.
    req_valid = 4'b0101;
    req_addr[0 +: 16] = 16'h0055;
    req_addr[32 +: 16] = 16'h0077;
    tick();
    req_valid = '0;
    tick();
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    check("mid_busy", msg_busy, 4'b0101);
    reset_n = 1'b0;
    #1;
    check("mid_async_req_ready", req_ready, 0);
    check("mid_async_busy", msg_busy, 0);
    check("mid_async_err", err_unexp_valid, 0);
    check("mid_async_resp", resp_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_rel_ready", req_ready, 4'hF);
    check("mid_rel_busy", msg_busy, 0);
    mem_rd_valid = 1'b1;
    tick();
    mem_rd_valid = 1'b0;
    check("mid_late_err", err_unexp_valid, 1);
    check("mid_late_resp", resp_valid, 0);
    tick();
    tick();
    check("mid_fifo_empty", mem_rd_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
